// File: rtl/mealy_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mealy_seq_ctrl
// Description : Run sequencer for the 5-state Mealy FSM block. Loads a start
//               state, steps the FSM once per latched switch symbol, captures
//               each output bit and the final state, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_seq_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int ST_W    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       seq_len,
    input  logic [2*MAX_LEN-1:0]   seq_data,
    input  logic [ST_W-1:0]        init_state,
    input  logic                   pause,
    input  logic [ST_W-1:0]        fsm_state,
    input  logic                   fsm_out,
    output logic                   fsm_reset,
    output logic [ST_W-1:0]        fsm_init,
    output logic [1:0]             fsm_sw,
    output logic                   fsm_ctrl,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [MAX_LEN-1:0]     out_bits,
    output logic [ST_W-1:0]        final_state
);

    localparam int               c_idx_w   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

    // S_REJECT spends one cycle so a rejected run reports done one edge later,
    // matching the timing seen by the front end.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_STEP    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5,
        S_REJECT  = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [LEN_W-1:0]       r_len;
    logic [2*MAX_LEN-1:0]   r_data;
    logic [ST_W-1:0]        r_init;
    logic [c_idx_w-1:0]     r_idx;
    logic [MAX_LEN-1:0]     r_out_bits;
    logic [ST_W-1:0]        r_final;
    logic                   r_err;

    logic                   w_bad_len;
    logic                   w_last;
    logic [1:0]             w_sym;

    assign w_bad_len = (seq_len == '0) || (seq_len > c_max_len);
    assign w_last    = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));
    assign w_sym     = r_data[{r_idx, 1'b0} +: 2];

    always_comb begin
        w_state_nxt = r_state;
        fsm_reset   = 1'b0;
        fsm_ctrl    = 1'b0;
        fsm_sw      = 2'b00;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_bad_len ? S_REJECT : S_LOAD;
                end
            end
            S_REJECT: begin
                w_state_nxt = S_DONE;
            end
            S_LOAD: begin
                busy        = 1'b1;
                fsm_reset   = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy        = 1'b1;
                w_state_nxt = S_STEP;
            end
            S_STEP: begin
                busy   = 1'b1;
                fsm_sw = w_sym;
                if (!pause) begin
                    fsm_ctrl    = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy        = 1'b1;
                w_state_nxt = w_last ? S_DONE : S_STEP;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_data     <= '0;
            r_init     <= '0;
            r_idx      <= '0;
            r_out_bits <= '0;
            r_final    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len      <= seq_len;
                        r_data     <= seq_data;
                        r_init     <= init_state;
                        r_out_bits <= '0;
                        r_final    <= '0;
                        r_err      <= w_bad_len;
                    end
                end
                S_CAPTURE: begin
                    r_out_bits[r_idx] <= fsm_out;
                    r_final           <= fsm_state;
                    if (!w_last) begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                S_DONE: begin
                    r_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign fsm_init    = r_init;
    assign out_bits    = r_out_bits;
    assign final_state = r_final;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mealy_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_seq_ctrl
// Description : Scoreboard bench for mealy_seq_ctrl with a stand-in Mealy FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  seq_len = '0;
    logic [31:0] seq_data = '0;
    logic [2:0]  init_state = '0;
    logic        pause = 1'b0;
    logic [2:0]  fsm_state;
    logic        fsm_out;
    logic        fsm_reset;
    logic [2:0]  fsm_init;
    logic [1:0]  fsm_sw;
    logic        fsm_ctrl;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] out_bits;
    logic [2:0]  final_state;

    mealy_seq_ctrl #(.MAX_LEN(16), .LEN_W(5), .ST_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .seq_len(seq_len),
        .seq_data(seq_data), .init_state(init_state), .pause(pause),
        .fsm_state(fsm_state), .fsm_out(fsm_out), .fsm_reset(fsm_reset),
        .fsm_init(fsm_init), .fsm_sw(fsm_sw), .fsm_ctrl(fsm_ctrl),
        .busy(busy), .done(done), .err(err), .out_bits(out_bits),
        .final_state(final_state)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        logic [2:0]  fin;
        logic        err;
        logic [2:0]  init;
        int          done_cyc;
        int          rst_cyc;
        int          n_ctrl;
        int          n_rst;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  sym_q[$];
    exp_t        last;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pz[16];

    // Stand-in FSM: state 4 holds on sw=3 (out 1); states 0..3 advance when
    // sw matches the low state bits; out is 1 for (4,3) and (1,1).
    function automatic logic [2:0] fsm_nxt(input logic [2:0] s, input logic [1:0] sw);
        if (s == 3'd4) return (sw == 2'd3) ? 3'd4 : 3'd0;
        if (s > 3'd4)  return 3'd0;
        if (sw == s[1:0]) return {1'b0, s[1:0] + 2'd1};
        return s;
    endfunction

    function automatic logic fsm_o(input logic [2:0] s, input logic [1:0] sw);
        return ((s == 3'd4) && (sw == 2'd3)) || ((s == 3'd1) && (sw == 2'd1));
    endfunction

    logic [2:0] m_st = '0;
    logic       m_q = 1'b0;
    assign fsm_state = m_st;
    assign fsm_out   = m_q;
    initial forever begin
        @(posedge clk);
        if (fsm_reset) begin
            m_st <= fsm_init;
            m_q  <= 1'b0;
        end else if (fsm_ctrl) begin
            m_st <= fsm_nxt(m_st, fsm_sw);
            m_q  <= fsm_o(m_st, fsm_sw);
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic exp_t model(input logic [2:0] init, input logic [4:0] len,
                                   input logic [31:0] data);
        exp_t       e;
        logic [2:0] s;
        logic [1:0] sw;
        e.bits = '0; e.fin = '0; e.err = 1'b0; e.init = init;
        e.done_cyc = 0; e.rst_cyc = 0; e.n_ctrl = 0; e.n_rst = 0;
        if (len == 0 || len > 16) begin
            e.err = 1'b1;
        end else begin
            s = init;
            for (int i = 0; i < int'(len); i++) begin
                sw        = data[2*i +: 2];
                e.bits[i] = fsm_o(s, sw);
                s         = fsm_nxt(s, sw);
            end
            e.fin    = s;
            e.n_ctrl = int'(len);
            e.n_rst  = 1;
        end
        return e;
    endfunction

    // Monitor: pops expectations on every done pulse and every step strobe.
    initial begin
        int         n_ctrl = 0;
        int         n_rst = 0;
        int         rst_at = 0;
        exp_t       e;
        logic [1:0] s;
        forever begin
            @(negedge clk);
            if (reset) begin
                n_ctrl = 0;
                n_rst  = 0;
                continue;
            end
            if (fsm_reset) begin
                n_rst++;
                rst_at = cyc;
            end
            if (fsm_ctrl) begin
                n_ctrl++;
                if (sym_q.size() == 0) flag("unexpected_fsm_ctrl");
                else begin
                    s = sym_q.pop_front();
                    chk("step_sw", 32'(fsm_sw), 32'(s));
                end
            end
            if (done) begin
                if (sb.size() == 0) flag("unexpected_done");
                else begin
                    e = sb.pop_front();
                    chk("out_bits", 32'(out_bits), 32'(e.bits));
                    chk("final_state", 32'(final_state), 32'(e.fin));
                    chk("err", 32'(err), 32'(e.err));
                    chk("fsm_init", 32'(fsm_init), 32'(e.init));
                    chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    chk("ctrl_pulses", 32'(n_ctrl), 32'(e.n_ctrl));
                    chk("fsm_reset_pulses", 32'(n_rst), 32'(e.n_rst));
                    chk("busy_at_done", 32'({busy, fsm_sw}), 32'(0));
                    if (!e.err) chk("fsm_reset_cycle", 32'(rst_at), 32'(e.rst_cyc));
                end
                n_ctrl = 0;
                n_rst  = 0;
            end
        end
    end

    task automatic scramble();
        start      = 1'($urandom);
        seq_len    = 5'($urandom);
        seq_data   = $urandom;
        init_state = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 80) flag("idle_wait_timeout");
    endtask

    task automatic do_run(input logic [2:0] init, input logic [4:0] len, input logic [31:0] data);
        exp_t e;
        int   tot;
        wait_idle();
        chk("hold_out_bits", 32'(out_bits), 32'(last.bits));
        chk("hold_final", 32'(final_state), 32'(last.fin));
        chk("hold_err", 32'(err), 32'(last.err));
        e   = model(init, len, data);
        tot = 0;
        if (!e.err) for (int k = 0; k < int'(len); k++) tot += pz[k];
        e.rst_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + (e.err ? 1 : 2 * int'(len) + 2 + tot);
        sb.push_back(e);
        if (!e.err) for (int k = 0; k < int'(len); k++) sym_q.push_back(data[2*k +: 2]);
        last       = e;
        start      = 1'b1;
        seq_len    = len;
        seq_data   = data;
        init_state = init;
        pause      = 1'b0;
        if (e.err) begin
            @(posedge clk); #1; scramble(); pause = 1'($urandom);
        end else begin
            repeat (2) begin
                @(posedge clk); #1; scramble(); pause = 1'($urandom);
            end
            for (int k = 0; k < int'(len); k++) begin
                for (int j = 0; j < pz[k]; j++) begin
                    @(posedge clk); #1; scramble(); pause = 1'b1;
                    #2;
                    chk("pause_ctrl_low", 32'(fsm_ctrl), 32'(0));
                    chk("pause_sw_stable", 32'(fsm_sw), 32'(data[2*k +: 2]));
                end
                @(posedge clk); #1; scramble(); pause = 1'b0;
                @(posedge clk); #1; scramble(); pause = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic clear_pz();
        for (int k = 0; k < 16; k++) pz[k] = 0;
    endtask

    initial begin
        logic [4:0] len;
        last.bits = '0; last.fin = '0; last.err = 1'b0;
        clear_pz();
        #1 reset = 1'b1;
        #2;
        chk("reset_outputs", 32'({busy, done, err, fsm_reset, fsm_ctrl, fsm_sw,
                                  fsm_init, final_state, out_bits}), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        do_run(3'd0, 5'd4, 32'h0000_00E4);
        do_run(3'd4, 5'd3, 32'h0000_003F);
        pz[1] = 5;
        do_run(3'd0, 5'd4, 32'h0000_00E4);
        clear_pz();
        do_run(3'd2, 5'd0, 32'h1234_5678);
        do_run(3'd1, 5'd17, 32'h8765_4321);
        do_run(3'd0, 5'd4, 32'h0000_00E4);
        do_run(3'd3, 5'd16, 32'hFFFF_0000);

        // Reset landing in the capture cycle of the second step.
        wait_idle();
        start = 1'b1; seq_len = 5'd4; seq_data = 32'h0000_00E4; init_state = 3'd0;
        for (int k = 0; k < 4; k++) sym_q.push_back(2'(k));
        repeat (6) begin
            @(posedge clk); #1; start = 1'b0;
        end
        chk("busy_before_reset", 32'(busy), 32'(1));
        reset = 1'b1;
        #1;
        chk("reset_mid_run", 32'({busy, done, err, fsm_reset, fsm_ctrl, fsm_sw,
                                  fsm_init, final_state, out_bits}), 32'(0));
        sym_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        last.bits = '0; last.fin = '0; last.err = 1'b0;
        do_run(3'd0, 5'd4, 32'h0000_00E4);

        for (int r = 0; r < 40; r++) begin
            len = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(1, 16));
            for (int k = 0; k < 16; k++)
                pz[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_run(3'($urandom_range(0, 4)), len, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        chk("symbols_drained", 32'(sym_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
